// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state codes and control-field encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Controller states, also exported on state_dbg
   typedef logic [3:0] state_t;
   localparam state_t S_FETCH   = 4'd0;
   localparam state_t S_DECODE  = 4'd1;
   localparam state_t S_EXEC_R  = 4'd2;
   localparam state_t S_EXEC_I  = 4'd3;
   localparam state_t S_MEM_RD  = 4'd4;
   localparam state_t S_MEM_WR  = 4'd5;
   localparam state_t S_WB_MEM  = 4'd6;
   localparam state_t S_WB_ALU  = 4'd7;
   localparam state_t S_WB_LUI  = 4'd8;
   localparam state_t S_BRANCH  = 4'd9;
   localparam state_t S_JUMP    = 4'd10;
   localparam state_t S_ILLEGAL = 4'd11;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCB_RT     = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } alu_src_b_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_source_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - controller <-> datapath/memory signal bundle
interface mips_multicycle_control_if #(parameter int CNT_W = 32);
   logic [5:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic             ir_write;
   logic             reg_write;
   logic             mem_read;
   logic             mem_write;
   logic             i_or_d;
   logic             mem_to_reg;
   logic             reg_dst;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       pc_source;
   logic             lui_ctrl;
   logic             load_ctrl;
   logic             store_ctrl;
   logic             illegal;
   logic [CNT_W-1:0] instr_retired;
   logic [3:0]       state_dbg;

   // Controller side
   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, i_or_d,
             mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
             lui_ctrl, load_ctrl, store_ctrl, illegal, instr_retired, state_dbg
   );

   // Datapath / memory side
   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, i_or_d,
             mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
             lui_ctrl, load_ctrl, store_ctrl, illegal, instr_retired, state_dbg
   );
endinterface

// File: rtl/mips_opcode_decode.sv
// rtl/mips_opcode_decode.sv - combinational opcode classifier
import mips_ctrl_pkg::*;

module mips_opcode_decode (
   input  logic [5:0] opcode,
   output logic       is_rtype,
   output logic       is_load,
   output logic       is_store,
   output logic       is_addi,
   output logic       is_lui,
   output logic       is_beq,
   output logic       is_j,
   output logic       full_word,
   output logic       illegal_op
);

   // Map each supported opcode onto its instruction class
   always_comb begin
      is_rtype   = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_addi    = 1'b0;
      is_lui     = 1'b0;
      is_beq     = 1'b0;
      is_j       = 1'b0;
      full_word  = 1'b0;
      illegal_op = 1'b0;
      case (opcode)
         OP_RTYPE:                        is_rtype = 1'b1;
         OP_LW:                           begin is_load = 1'b1; full_word = 1'b1; end
         OP_LB, OP_LH, OP_LBU, OP_LHU:    is_load = 1'b1;
         OP_SW:                           begin is_store = 1'b1; full_word = 1'b1; end
         OP_SB, OP_SH:                    is_store = 1'b1;
         OP_ADDI:                         is_addi = 1'b1;
         OP_LUI:                          is_lui = 1'b1;
         OP_BEQ:                          is_beq = 1'b1;
         OP_J:                            is_j = 1'b1;
         default:                         illegal_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Moore FSM sequencing the shared multi-cycle MIPS datapath
import mips_ctrl_pkg::*;

module mips_multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   mips_multicycle_control_if.master  bus
);

   state_t           state;
   state_t           nextState;
   state_t           outState;
   logic [CNT_W-1:0] retiredCnt;
   logic             illegalFlag;
   logic             retire;

   logic isRtype, isLoad, isStore, isAddi, isLui, isBeq, isJ, fullWord, illegalOp;

   logic       pcWrite, pcWriteCond, irWrite, regWrite, memRead, memWrite;
   logic       iOrD, memToReg, regDst, aluSrcA, luiCtrl, loadCtrl, storeCtrl;
   logic [1:0] aluSrcB, aluOp, pcSource;

   mips_opcode_decode uDecode (
      .opcode     (bus.opcode),
      .is_rtype   (isRtype),
      .is_load    (isLoad),
      .is_store   (isStore),
      .is_addi    (isAddi),
      .is_lui     (isLui),
      .is_beq     (isBeq),
      .is_j       (isJ),
      .full_word  (fullWord),
      .illegal_op (illegalOp)
   );

   // Next-state selection; mem_ready only matters in the three memory states
   always_comb begin
      nextState = state;
      case (state)
         S_FETCH:   if (bus.mem_ready) nextState = S_DECODE;
         S_DECODE: begin
            if (isRtype)                           nextState = S_EXEC_R;
            else if (isLoad || isStore || isAddi)  nextState = S_EXEC_I;
            else if (isLui)                        nextState = S_WB_LUI;
            else if (isBeq)                        nextState = S_BRANCH;
            else if (isJ)                          nextState = S_JUMP;
            else                                   nextState = S_ILLEGAL;
         end
         S_EXEC_R:  nextState = S_WB_ALU;
         S_EXEC_I: begin
            if (isLoad)       nextState = S_MEM_RD;
            else if (isStore) nextState = S_MEM_WR;
            else              nextState = S_WB_ALU;
         end
         S_MEM_RD:  if (bus.mem_ready) nextState = S_WB_MEM;
         S_MEM_WR:  if (bus.mem_ready) nextState = S_FETCH;
         S_WB_MEM, S_WB_ALU, S_WB_LUI, S_BRANCH, S_JUMP: nextState = S_FETCH;
         S_ILLEGAL: nextState = S_ILLEGAL;
         default:   nextState = S_FETCH;
      endcase
   end

   // An instruction retires on the cycle it hands control back to FETCH
   assign retire = (state != S_FETCH) && (nextState == S_FETCH);

   // State, retired counter and sticky illegal flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_FETCH;
         retiredCnt  <= '0;
         illegalFlag <= 1'b0;
      end else begin
         state <= nextState;
         if (retire)
            retiredCnt <= retiredCnt + 1'b1;
         if (nextState == S_ILLEGAL)
            illegalFlag <= 1'b1;
      end
   end

   // While in reset the outputs look like an idle FETCH with every strobe held low
   assign outState = rst ? S_FETCH : state;

   // Moore output decode; only the FETCH strobes peek at mem_ready
   always_comb begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      irWrite     = 1'b0;
      regWrite    = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      iOrD        = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = SRCB_RT;
      aluOp       = ALU_ADD;
      pcSource    = PCSRC_ALU;
      luiCtrl     = 1'b0;
      loadCtrl    = 1'b0;
      storeCtrl   = 1'b0;
      case (outState)
         S_FETCH: begin
            memRead = ~rst;
            aluSrcB = SRCB_FOUR;
            irWrite = bus.mem_ready & ~rst;
            pcWrite = bus.mem_ready & ~rst;
         end
         S_DECODE:  aluSrcB = SRCB_IMM_SH;
         S_EXEC_R: begin
            aluSrcA = 1'b1;
            aluOp   = ALU_FUNCT;
         end
         S_EXEC_I: begin
            aluSrcA = 1'b1;
            aluSrcB = SRCB_IMM;
         end
         S_MEM_RD: begin
            memRead = 1'b1;
            iOrD    = 1'b1;
         end
         S_MEM_WR: begin
            memWrite  = 1'b1;
            iOrD      = 1'b1;
            storeCtrl = fullWord;
         end
         S_WB_MEM: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
            loadCtrl = fullWord;
         end
         S_WB_ALU: begin
            regWrite = 1'b1;
            regDst   = isRtype;
         end
         S_WB_LUI: begin
            regWrite = 1'b1;
            luiCtrl  = 1'b1;
         end
         S_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = ALU_SUB;
            pcWriteCond = 1'b1;
            pcSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pcWrite  = 1'b1;
            pcSource = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign bus.pc_write      = pcWrite;
   assign bus.pc_write_cond = pcWriteCond;
   assign bus.ir_write      = irWrite;
   assign bus.reg_write     = regWrite;
   assign bus.mem_read      = memRead;
   assign bus.mem_write     = memWrite;
   assign bus.i_or_d        = iOrD;
   assign bus.mem_to_reg    = memToReg;
   assign bus.reg_dst       = regDst;
   assign bus.alu_src_a     = aluSrcA;
   assign bus.alu_src_b     = aluSrcB;
   assign bus.alu_op        = aluOp;
   assign bus.pc_source     = pcSource;
   assign bus.lui_ctrl      = luiCtrl;
   assign bus.load_ctrl     = loadCtrl;
   assign bus.store_ctrl    = storeCtrl;
   assign bus.illegal       = illegalFlag & ~rst;
   assign bus.instr_retired = retiredCnt;
   assign bus.state_dbg     = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - self-checking bench for mips_multicycle_control
import mips_ctrl_pkg::*;

module tb_mips_multicycle_control;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mips_multicycle_control_if #(.CNT_W(32)) ifA ();
   mips_multicycle_control_if #(.CNT_W(2))  ifB ();

   mips_multicycle_control #(.CNT_W(32)) dutA (.clk(clk), .rst(rst), .bus(ifA));
   mips_multicycle_control #(.CNT_W(2))  dutB (.clk(clk), .rst(rst), .bus(ifB));

   // Packed view of every control output, same order as the expectation function
   wire [19:0] outA = {ifA.pc_write, ifA.pc_write_cond, ifA.ir_write, ifA.reg_write,
                       ifA.mem_read, ifA.mem_write, ifA.i_or_d, ifA.mem_to_reg, ifA.reg_dst,
                       ifA.alu_src_a, ifA.alu_src_b, ifA.alu_op, ifA.pc_source,
                       ifA.lui_ctrl, ifA.load_ctrl, ifA.store_ctrl, ifA.illegal};
   wire [19:0] outB = {ifB.pc_write, ifB.pc_write_cond, ifB.ir_write, ifB.reg_write,
                       ifB.mem_read, ifB.mem_write, ifB.i_or_d, ifB.mem_to_reg, ifB.reg_dst,
                       ifB.alu_src_a, ifB.alu_src_b, ifB.alu_op, ifB.pc_source,
                       ifB.lui_ctrl, ifB.load_ctrl, ifB.store_ctrl, ifB.illegal};

   typedef enum int {K_FETCH, K_DECODE, K_EXEC_R, K_EXEC_I, K_MEM_RD, K_MEM_WR,
                     K_WB_MEM, K_WB_ALU, K_WB_LUI, K_BRANCH, K_JUMP, K_ILLEGAL} kind_t;

   typedef enum int {C_R, C_LOAD, C_STORE, C_ADDI, C_LUI, C_BEQ, C_J, C_BAD} iclass_t;

   int          nChecks = 0;
   int          nFails  = 0;
   longint      retired = 0;
   logic [5:0]  legalOps [13] = '{6'b000000, 6'b100011, 6'b100000, 6'b100001, 6'b100100,
                                  6'b100101, 6'b101011, 6'b101000, 6'b101001, 6'b001000,
                                  6'b001111, 6'b000100, 6'b000010};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      assert (got === exp) else begin
         nFails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic iclass_t classOf(input logic [5:0] op);
      case (op)
         6'b000000:                                     return C_R;
         6'b100011, 6'b100000, 6'b100001,
         6'b100100, 6'b100101:                          return C_LOAD;
         6'b101011, 6'b101000, 6'b101001:               return C_STORE;
         6'b001000:                                     return C_ADDI;
         6'b001111:                                     return C_LUI;
         6'b000100:                                     return C_BEQ;
         6'b000010:                                     return C_J;
         default:                                       return C_BAD;
      endcase
   endfunction

   // Expected outputs for one cycle, straight from the per-step control table
   function automatic logic [19:0] expOut(input kind_t k, input logic [5:0] op, input logic rdy);
      logic pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, lui, ld, st, ill;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, lui, ld, st, ill} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (k)
         K_FETCH:   begin mr = 1'b1; asb = 2'b01; pw = rdy; irw = rdy; end
         K_DECODE:  asb = 2'b11;
         K_EXEC_R:  begin asa = 1'b1; aop = 2'b10; end
         K_EXEC_I:  begin asa = 1'b1; asb = 2'b10; end
         K_MEM_RD:  begin mr = 1'b1; iod = 1'b1; end
         K_MEM_WR:  begin mw = 1'b1; iod = 1'b1; st = (op == 6'b101011); end
         K_WB_MEM:  begin rw = 1'b1; m2r = 1'b1; ld = (op == 6'b100011); end
         K_WB_ALU:  begin rw = 1'b1; rd = (op == 6'b000000); end
         K_WB_LUI:  begin rw = 1'b1; lui = 1'b1; end
         K_BRANCH:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
         K_JUMP:    begin pw = 1'b1; psrc = 2'b10; end
         K_ILLEGAL: ill = 1'b1;
         default: ;
      endcase
      return {pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, asb, aop, psrc, lui, ld, st, ill};
   endfunction

   function automatic logic [3:0] expState(input kind_t k);
      case (k)
         K_FETCH:   return S_FETCH;
         K_DECODE:  return S_DECODE;
         K_EXEC_R:  return S_EXEC_R;
         K_EXEC_I:  return S_EXEC_I;
         K_MEM_RD:  return S_MEM_RD;
         K_MEM_WR:  return S_MEM_WR;
         K_WB_MEM:  return S_WB_MEM;
         K_WB_ALU:  return S_WB_ALU;
         K_WB_LUI:  return S_WB_LUI;
         K_BRANCH:  return S_BRANCH;
         K_JUMP:    return S_JUMP;
         default:   return S_ILLEGAL;
      endcase
   endfunction

   // One clock of stimulus with checks taken 1 time unit after the falling edge
   task automatic step(input kind_t k, input logic [5:0] op, input logic rdy);
      logic z;
      z = 1'($urandom_range(0, 1));
      ifA.mem_ready = rdy; ifB.mem_ready = rdy;
      ifA.zero = z;        ifB.zero = z;
      #1;
      chk("outputs", 32'(outA), 32'(expOut(k, op, rdy)));
      chk("state", 32'(ifA.state_dbg), 32'(expState(k)));
      chk("retired", ifA.instr_retired, 32'(retired));
      chk("retired_w2", 32'(ifB.instr_retired), 32'(retired % 4));
      chk("outputs_w2", 32'(outB), 32'(expOut(k, op, rdy)));
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic runInstr(input logic [5:0] op, input int fWait, input int mWait);
      iclass_t c;
      c = classOf(op);
      ifA.opcode = op; ifB.opcode = op;
      repeat (fWait) step(K_FETCH, op, 1'b0);
      step(K_FETCH, op, 1'b1);
      step(K_DECODE, op, rnd());
      case (c)
         C_R:     begin step(K_EXEC_R, op, rnd()); step(K_WB_ALU, op, rnd()); end
         C_ADDI:  begin step(K_EXEC_I, op, rnd()); step(K_WB_ALU, op, rnd()); end
         C_LOAD: begin
            step(K_EXEC_I, op, rnd());
            repeat (mWait) step(K_MEM_RD, op, 1'b0);
            step(K_MEM_RD, op, 1'b1);
            step(K_WB_MEM, op, rnd());
         end
         C_STORE: begin
            step(K_EXEC_I, op, rnd());
            repeat (mWait) step(K_MEM_WR, op, 1'b0);
            step(K_MEM_WR, op, 1'b1);
         end
         C_LUI:   step(K_WB_LUI, op, rnd());
         C_BEQ:   step(K_BRANCH, op, rnd());
         C_J:     step(K_JUMP, op, rnd());
         default: repeat (4) step(K_ILLEGAL, op, rnd());
      endcase
      if (c != C_BAD)
         retired++;
   endtask

   // Reset cycle: strobes gated low, FETCH-like outputs on both instances
   task automatic rstCycle();
      rst = 1'b1;
      ifA.mem_ready = 1'b1; ifB.mem_ready = 1'b1;
      #1;
      chk("rst_outputs", 32'(outA), 32'h0000_0100);
      chk("rst_outputs_w2", 32'(outB), 32'h0000_0100);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      retired = 0;
   endtask

   initial begin
      rst = 1'b1;
      ifA.opcode = 6'b0; ifB.opcode = 6'b0;
      ifA.zero = 1'b0;   ifB.zero = 1'b0;
      ifA.mem_ready = 1'b0; ifB.mem_ready = 1'b0;
      @(negedge clk);
      rstCycle();

      // Directed: lw, FETCH wait, sb with memory wait, the R/addi/lui/beq/j mix
      runInstr(6'b100011, 0, 0);
      runInstr(6'b000000, 3, 0);
      runInstr(6'b101000, 0, 2);
      runInstr(6'b000000, 0, 0);
      runInstr(6'b001000, 0, 0);
      runInstr(6'b001111, 0, 0);
      runInstr(6'b000100, 0, 0);
      runInstr(6'b000010, 0, 0);

      // Random legal instruction stream with random memory latency
      for (int i = 0; i < 60; i++)
         runInstr(legalOps[$urandom_range(0, 12)], $urandom_range(0, 2), $urandom_range(0, 2));

      // Reset in MEM_RD abandons the load with no writeback
      ifA.opcode = 6'b100011; ifB.opcode = 6'b100011;
      step(K_FETCH, 6'b100011, 1'b1);
      step(K_DECODE, 6'b100011, 1'b1);
      step(K_EXEC_I, 6'b100011, 1'b1);
      rstCycle();
      runInstr(6'b100100, 1, 1);

      // Unsupported opcode: absorbing, sticky, counter frozen, cleared by reset
      runInstr(6'b111111, 0, 0);
      rstCycle();
      runInstr(6'b101011, 0, 1);
      runInstr(6'b000100, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle main controller that sequences the shared MIPS datapath (register file, ALU, unified instruction/data memory, extenders) over several clocks per instruction, replacing the single-cycle combinational control. It is a Moore FSM keyed on the IR opcode, with a ready handshake so the single memory can have variable latency. It also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE to end of instruction
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, ir_write, reg_write  out  1  register-update strobes
- mem_read, mem_write, i_or_d  out  1  memory request; i_or_d=1 selects ALUOut as address
- mem_to_reg, reg_dst, alu_src_a  out  1  datapath mux selects
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- lui_ctrl, load_ctrl, store_ctrl  out  1  lui writeback; load_ctrl/store_ctrl=1 full word, 0 byte/half
- illegal  out  1  sticky unsupported-opcode flag
- instr_retired  out  CNT_W  retired-instruction count
- state_dbg  out  4  current state encoding

## Operation
Supported opcodes: R 000000, lw 100011, lb 100000, lh 100001, lbu 100100, lhu 100101, sw 101011, sb 101000, sh 101001, addi 001000, lui 001111, beq 000100, j 000010. Unlisted fields are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Stays while !mem_ready; the cycle mem_ready=1 asserts ir_write=1, pc_write=1 and goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next: R->EXEC_R; loads/stores/addi->EXEC_I; lui->WB_LUI; beq->BRANCH; j->JUMP; other->ILLEGAL.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (load), MEM_WR (store), WB_ALU (addi).
- MEM_RD: mem_read=1, i_or_d=1; holds until mem_ready, then WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1, store_ctrl=(sw); holds until mem_ready, then FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, load_ctrl=(lw) -> FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=(R-type) -> FETCH.
- WB_LUI: reg_write=1, lui_ctrl=1, reg_dst=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH (PC updated externally iff zero).
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ILLEGAL: illegal=1, all strobes 0; absorbing until rst.
- instr_retired increments by 1 on the final cycle of each instruction (the cycle whose next state is FETCH); wraps modulo 2^CNT_W; never increments in ILLEGAL.

## Timing
- Reset: on the edge with rst=1, state<=FETCH, instr_retired<=0, illegal<=0. While rst=1, all strobes (pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write) are gated to 0. All other outputs are 0 or FETCH values. rst mid-instruction abandons it with no writeback.
- Outputs are combinational from the state register. Exceptions: ir_write and pc_write in FETCH, which also require mem_ready.
- Minimum cycles with mem_ready=1: beq/j/lui 3, R/addi/store 4, load 5. Each memory wait cycle adds 1.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored. mem_read and mem_write are never both 1.

## Structure
- Package mips_ctrl_pkg: opcode localparams, state enum (4-bit), alu_op/alu_src_b/pc_source encodings.
- Sub-module mips_opcode_decode: combinational classifier giving is_rtype, is_load, is_store, is_addi, is_lui, is_beq, is_j, full_word, illegal_op.

## Test plan
- Reset then lw with mem_ready always 1 -> states FETCH,DECODE,EXEC_I,MEM_RD,WB_MEM; reg_write=1, mem_to_reg=1, load_ctrl=1 in cycle 5; instr_retired=1.
- FETCH with mem_ready low 3 cycles -> ir_write/pc_write stay 0 for 3 cycles, pulse once in cycle 4; state_dbg held at FETCH.
- sb with mem_ready delayed 2 cycles in MEM_WR -> mem_write=1, i_or_d=1, store_ctrl=0 for 3 cycles; then FETCH; reg_write never 1.
- Sequence R, addi, lui, beq, j -> reg_dst 1/0/0, lui_ctrl only in WB_LUI, pc_write_cond=1 only in BRANCH, pc_source=10 in JUMP; instr_retired=5.
- Opcode 111111 -> ILLEGAL after DECODE; illegal=1 sticky, no strobes; counter frozen; rst clears it.
- rst asserted in MEM_RD -> next state FETCH, instr_retired=0, no reg_write. Preload counter to 2^32-1 and retire one instruction -> wraps to 0.
